// File: rtl/data_sram_like_slave.sv
// data_sram_like_slave
// Responder side of the SRAM-like data-memory interface used by the MEM stage.
// Requests are accepted via addr_ok and queued in order. After LATENCY cycles
// each one is answered with data_ok/rdata. Byte-strobed writes commit to the
// word array at the acceptance edge. Reads capture the word before any write
// at that same edge.
// Optional feature: define DSRAM_STALL_EN to add a 16-bit LFSR that randomly
// withholds addr_ok. This exercises MEM-stage request hold/stall behaviour.
module data_sram_like_slave #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_sram_req_i,
  input  logic        data_sram_wr_i,
  input  logic [1:0]  data_sram_size_i,
  input  logic [31:0] data_sram_addr_i,
  input  logic [3:0]  data_sram_wstrb_i,
  input  logic [31:0] data_sram_wdata_i,
  output logic        data_sram_addr_ok_o,
  output logic        data_sram_data_ok_o,
  output logic [31:0] data_sram_rdata_o
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam logic [2:0] QDEPTH_C = 3'(QDEPTH);
  localparam logic [1:0] PTR_LAST = 2'(QDEPTH - 1);

  // Circular pointer advance that wraps at the configured queue depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = 2'd0;
    end else begin
      ptr_inc = p + 2'd1;
    end
  endfunction

  // Backing word array; deliberately not reset so contents survive rst_n.
  logic [31:0] mem_r [0:(1 << ADDR_W) - 1];

  // Queue storage is sized for the largest legal depth; pointers wrap at QDEPTH.
  logic        q_wr_r    [4];
  logic [31:0] q_rdata_r [4];
  logic [2:0]  q_cnt_r   [4];
  logic [1:0]  head_r;
  logic [1:0]  tail_r;
  logic [2:0]  occ_r;

  logic        q_wr_nxt_s    [4];
  logic [31:0] q_rdata_nxt_s [4];
  logic [2:0]  q_cnt_nxt_s   [4];
  logic [1:0]  head_nxt_s;
  logic [1:0]  tail_nxt_s;
  logic [2:0]  occ_nxt_s;

  logic [ADDR_W-1:0] idx_s;
  logic              stall_s;
  logic              addr_ok_s;
  logic              data_ok_s;
  logic [31:0]       rdata_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_s;

  assign idx_s    = data_sram_addr_i[ADDR_W+1:2];
  // Size and out-of-range address bits carry no meaning for this responder.
  assign unused_s = ^{data_sram_size_i, data_sram_addr_i[31:ADDR_W+2], data_sram_addr_i[1:0]};

`ifdef DSRAM_STALL_EN
  logic [15:0] lfsr_r;

  // Fibonacci LFSR (taps 16,14,13,11) that free-runs every cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign stall_s = lfsr_r[0];
`else
  assign stall_s = 1'b0;
`endif

  // Handshake outputs, derived only from registered state and rst_n.
  always_comb begin
    addr_ok_s = rst_n & (occ_r < QDEPTH_C) & ~stall_s;
    data_ok_s = (occ_r != 3'd0) && (q_cnt_r[head_r] == 3'd0);
    if (data_ok_s && !q_wr_r[head_r]) begin
      rdata_s = q_rdata_r[head_r];
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign push_s = data_sram_req_i & addr_ok_s;
  assign pop_s  = data_ok_s;

  assign data_sram_addr_ok_o = addr_ok_s;
  assign data_sram_data_ok_o = data_ok_s;
  assign data_sram_rdata_o   = rdata_s;

  // Next queue state: age all counters, append the new request, retire the head.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_wr_nxt_s[i]    = q_wr_r[i];
      q_rdata_nxt_s[i] = q_rdata_r[i];
      if (q_cnt_r[i] != 3'd0) begin
        q_cnt_nxt_s[i] = q_cnt_r[i] - 3'd1;
      end else begin
        q_cnt_nxt_s[i] = 3'd0;
      end
    end
    if (push_s) begin
      q_wr_nxt_s[tail_r]    = data_sram_wr_i;
      q_rdata_nxt_s[tail_r] = data_sram_wr_i ? 32'd0 : mem_r[idx_s];
      q_cnt_nxt_s[tail_r]   = CNT_INIT;
      tail_nxt_s            = ptr_inc(tail_r);
    end else begin
      tail_nxt_s = tail_r;
    end
    if (pop_s) begin
      head_nxt_s = ptr_inc(head_r);
    end else begin
      head_nxt_s = head_r;
    end
    if (push_s && !pop_s) begin
      occ_nxt_s = occ_r + 3'd1;
    end else if (pop_s && !push_s) begin
      occ_nxt_s = occ_r - 3'd1;
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Queue state register; reset drops every outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= 2'd0;
      tail_r <= 2'd0;
      occ_r  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_wr_r[i]    <= 1'b0;
        q_rdata_r[i] <= 32'd0;
        q_cnt_r[i]   <= 3'd0;
      end
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      occ_r  <= occ_nxt_s;
      for (int i = 0; i < 4; i++) begin
        q_wr_r[i]    <= q_wr_nxt_s[i];
        q_rdata_r[i] <= q_rdata_nxt_s[i];
        q_cnt_r[i]   <= q_cnt_nxt_s[i];
      end
    end
  end

  // Byte-lane write into the array at the acceptance edge.
  always_ff @(posedge clk) begin
    if (push_s && data_sram_wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb_i[b]) begin
          mem_r[idx_s][8*b +: 8] <= data_sram_wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Testbench for data_sram_like_slave. Three instances with LATENCY 1, 3 and 2
// (all QDEPTH 2) share the clock and reset. Directed scenarios check
// handshake timing, data and ordering against hand-computed values.
module tb_data_sram_like_slave;

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic        wr    [3];
  logic [1:0]  size  [3];
  logic [31:0] addr  [3];
  logic [3:0]  wstrb [3];
  logic [31:0] wdata [3];
  logic        aok   [3];
  logic        dok   [3];
  logic [31:0] rdo   [3];

  int checks;
  int errors;

  data_sram_like_slave #(.ADDR_W(12), .LATENCY(1), .QDEPTH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .data_sram_req_i(req[0]), .data_sram_wr_i(wr[0]), .data_sram_size_i(size[0]),
    .data_sram_addr_i(addr[0]), .data_sram_wstrb_i(wstrb[0]), .data_sram_wdata_i(wdata[0]),
    .data_sram_addr_ok_o(aok[0]), .data_sram_data_ok_o(dok[0]), .data_sram_rdata_o(rdo[0])
  );

  data_sram_like_slave #(.ADDR_W(12), .LATENCY(3), .QDEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_sram_req_i(req[1]), .data_sram_wr_i(wr[1]), .data_sram_size_i(size[1]),
    .data_sram_addr_i(addr[1]), .data_sram_wstrb_i(wstrb[1]), .data_sram_wdata_i(wdata[1]),
    .data_sram_addr_ok_o(aok[1]), .data_sram_data_ok_o(dok[1]), .data_sram_rdata_o(rdo[1])
  );

  data_sram_like_slave #(.ADDR_W(12), .LATENCY(2), .QDEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .data_sram_req_i(req[2]), .data_sram_wr_i(wr[2]), .data_sram_size_i(size[2]),
    .data_sram_addr_i(addr[2]), .data_sram_wstrb_i(wstrb[2]), .data_sram_wdata_i(wdata[2]),
    .data_sram_addr_ok_o(aok[2]), .data_sram_data_ok_o(dok[2]), .data_sram_rdata_o(rdo[2])
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
    req[d]   = r;
    wr[d]    = w;
    addr[d]  = a;
    wstrb[d] = s;
    wdata[d] = wd;
  endtask

  // Issue one request on instance d and wait (bounded) for its response.
  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd);
    int n;
    drive(d, 1'b1, w, a, s, wd);
    n = 0;
    while (!aok[d] && n < 20) begin
      tick();
      n++;
    end
    if (!aok[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: addr_ok never rose", d);
    end
    tick();
    req[d] = 1'b0;
    n = 0;
    while (!dok[d] && n < 20) begin
      tick();
      n++;
    end
    if (!dok[d]) begin
      checks++; errors++;
      $display("FAIL response_timeout dut%0d: data_ok never rose", d);
    end
    rd = rdo[d];
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (aok[d] !== 1'b0 || dok[d] !== 1'b0 || rdo[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: addr_ok=%b data_ok=%b rdata=%h, want 0/0/0",
                 d, aok[d], dok[d], rdo[d]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (aok[d] !== 1'b1 || dok[d] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset dut%0d: addr_ok=%b data_ok=%b, want 1/0", d, aok[d], dok[d]);
      end
    end
  endtask

  task automatic test_basic();
    drive(0, 1'b1, 1'b1, 32'h0000_0400, 4'hF, 32'hDEADBEEF);
    checks++;
    if (aok[0] !== 1'b1) begin
      errors++; $display("FAIL basic_wr_addr_ok: got %b want 1", aok[0]);
    end
    tick();
    checks++;
    if (dok[0] !== 1'b1 || rdo[0] !== 32'd0) begin
      errors++; $display("FAIL basic_wr_resp: data_ok=%b rdata=%h want 1/00000000", dok[0], rdo[0]);
    end
    drive(0, 1'b1, 1'b0, 32'h0000_0400, 4'h0, 32'd0);
    tick();
    req[0] = 1'b0;
    checks++;
    if (dok[0] !== 1'b1 || rdo[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_rd_resp: data_ok=%b rdata=%h want 1/deadbeef", dok[0], rdo[0]);
    end
    tick();
    checks++;
    if (dok[0] !== 1'b0 || rdo[0] !== 32'd0) begin
      errors++; $display("FAIL basic_idle: data_ok=%b rdata=%h want 0/00000000", dok[0], rdo[0]);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd;
    do_req(0, 1'b1, 32'h0000_0800, 4'hF, 32'h11223344, rd);
    do_req(0, 1'b1, 32'h0000_0800, 4'b0100, 32'h00AA0000, rd);
    do_req(0, 1'b0, 32'h0000_0800, 4'h0, 32'd0, rd);
    checks++;
    if (rd !== 32'h11AA3344) begin
      errors++; $display("FAIL byte_write: got %h want 11aa3344", rd);
    end
    do_req(0, 1'b1, 32'h0000_0800, 4'h0, 32'hFFFFFFFF, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL zero_strobe_resp: got %h want 00000000", rd);
    end
    do_req(0, 1'b0, 32'h0000_0800, 4'h0, 32'd0, rd);
    checks++;
    if (rd !== 32'h11AA3344) begin
      errors++; $display("FAIL zero_strobe_nowrite: got %h want 11aa3344", rd);
    end
  endtask

  task automatic test_queue_full();
    logic [31:0] rd;
    do_req(1, 1'b1, 32'h0000_0040, 4'hF, 32'hA0A0A0A0, rd);
    do_req(1, 1'b1, 32'h0000_0044, 4'hF, 32'hB1B1B1B1, rd);
    do_req(1, 1'b1, 32'h0000_0048, 4'hF, 32'hC2C2C2C2, rd);
    // c0: first read
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'd0);
    checks++;
    if (aok[1] !== 1'b1) begin errors++; $display("FAIL q_c0_addr_ok: got %b want 1", aok[1]); end
    tick();
    // c1: second read
    drive(1, 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'd0);
    checks++;
    if (aok[1] !== 1'b1 || dok[1] !== 1'b0) begin
      errors++; $display("FAIL q_c1: addr_ok=%b data_ok=%b want 1/0", aok[1], dok[1]);
    end
    tick();
    // c2: third read held while the queue is full
    drive(1, 1'b1, 1'b0, 32'h0000_0048, 4'h0, 32'd0);
    checks++;
    if (aok[1] !== 1'b0 || dok[1] !== 1'b0) begin
      errors++; $display("FAIL q_c2_full: addr_ok=%b data_ok=%b want 0/0", aok[1], dok[1]);
    end
    tick();
    checks++;
    if (aok[1] !== 1'b0 || dok[1] !== 1'b1 || rdo[1] !== 32'hA0A0A0A0) begin
      errors++; $display("FAIL q_c3_first: addr_ok=%b data_ok=%b rdata=%h want 0/1/a0a0a0a0",
                         aok[1], dok[1], rdo[1]);
    end
    tick();
    checks++;
    if (aok[1] !== 1'b1 || dok[1] !== 1'b1 || rdo[1] !== 32'hB1B1B1B1) begin
      errors++; $display("FAIL q_c4_second: addr_ok=%b data_ok=%b rdata=%h want 1/1/b1b1b1b1",
                         aok[1], dok[1], rdo[1]);
    end
    tick();
    req[1] = 1'b0;
    checks++;
    if (dok[1] !== 1'b0) begin errors++; $display("FAIL q_c5_gap: data_ok=%b want 0", dok[1]); end
    tick();
    checks++;
    if (dok[1] !== 1'b0) begin errors++; $display("FAIL q_c6_gap: data_ok=%b want 0", dok[1]); end
    tick();
    checks++;
    if (dok[1] !== 1'b1 || rdo[1] !== 32'hC2C2C2C2) begin
      errors++; $display("FAIL q_c7_third: data_ok=%b rdata=%h want 1/c2c2c2c2", dok[1], rdo[1]);
    end
    tick();
  endtask

  task automatic test_ordering();
    drive(2, 1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'hCAFEF00D);
    tick();
    drive(2, 1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'd0);
    checks++;
    if (aok[2] !== 1'b1 || dok[2] !== 1'b0) begin
      errors++; $display("FAIL ord_c1: addr_ok=%b data_ok=%b want 1/0", aok[2], dok[2]);
    end
    tick();
    req[2] = 1'b0;
    checks++;
    if (dok[2] !== 1'b1 || rdo[2] !== 32'd0) begin
      errors++; $display("FAIL ord_wr_resp: data_ok=%b rdata=%h want 1/00000000", dok[2], rdo[2]);
    end
    tick();
    checks++;
    if (dok[2] !== 1'b1 || rdo[2] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ord_rd_resp: data_ok=%b rdata=%h want 1/cafef00d", dok[2], rdo[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int seen;
    drive(1, 1'b1, 1'b1, 32'h0000_0130, 4'hF, 32'h5A5A1234);
    tick();
    drive(1, 1'b1, 1'b0, 32'h0000_0130, 4'h0, 32'd0);
    tick();
    req[1] = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (aok[1] !== 1'b0 || dok[1] !== 1'b0 || rdo[1] !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs: addr_ok=%b data_ok=%b rdata=%h want 0/0/0",
                         aok[1], dok[1], rdo[1]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (aok[1] !== 1'b1) begin errors++; $display("FAIL midrst_addr_ok: got %b want 1", aok[1]); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (dok[1]) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_dropped: saw %0d responses want 0", seen);
    end
    do_req(1, 1'b0, 32'h0000_0130, 4'h0, 32'd0, rd);
    checks++;
    if (rd !== 32'h5A5A1234) begin
      errors++; $display("FAIL midrst_persist: got %h want 5a5a1234", rd);
    end
  endtask

  task automatic test_stall();
    logic [15:0] model;
    int acc_exp;
    int resp;
    rst_n = 1'b0;
    tick();
    model   = 16'hACE1;
    acc_exp = 0;
    resp    = 0;
    rst_n   = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (aok[0] !== ~model[0]) begin
        errors++; $display("FAIL stall_pattern cycle %0d: addr_ok=%b want %b", i, aok[0], ~model[0]);
      end
      if (!model[0]) acc_exp++;
      if (dok[0]) resp++;
      tick();
      model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
    end
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dok[0]) resp++;
      tick();
    end
    checks++;
    if (resp != acc_exp) begin
      errors++; $display("FAIL stall_accept_count: got %0d want %0d", resp, acc_exp);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 3; d++) begin
      size[d] = 2'd2;
      drive(d, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    end
`ifdef DSRAM_STALL_EN
    test_stall();
`else
    test_reset();
    test_basic();
    test_byte_write();
    test_queue_full();
    test_ordering();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
